// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM state type and default frame geometry for shift_sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_e;
  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_DIV = 4;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: clocks-per-bit divider and bit counter for one serial frame
//   clear    in  restart both counters (frame accept)
//   run      in  counting enabled (SHIFT state)
//   bit_end  out last clock of the current bit
//   last_bit out last clock of the final bit of the frame
//   sclk     out high for the first DIV/2 clocks of each bit while running
module bit_timer import shift_seq_pkg::*; #(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DIV = SEQ_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic last_bit,
  output logic sclk
);
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(WIDTH);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  assign bit_end = run && div_cnt == DW'(DIV - 1);
  assign last_bit = bit_end && bit_cnt == BW'(WIDTH - 1);
  assign sclk = run && div_cnt < DW'(DIV / 2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      div_cnt <= '0;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end else if (run) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: full-duplex MSB-first serial shift engine with built-in bit timing
//   tx_data/tx_valid/tx_ready  parallel word in, accepted only in IDLE
//   serial_out/serial_in       serial pin pair, serial_in sampled at each bit end
//   sclk                       bit strobe, frame high for the whole transfer
//   rx_data/rx_valid           received word with one-cycle update pulse
//   busy                       transfer in progress (SHIFT or DONE)
module shift_sequencer import shift_seq_pkg::*; #(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DIV = SEQ_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             serial_out,
  input  logic             serial_in,
  output logic             sclk,
  output logic             frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);
  if (WIDTH < 2 || DIV < 2) begin : g_param_check
    $error("shift_sequencer: WIDTH and DIV must both be >= 2");
  end
  seq_state_e state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic accept, bit_end, last_bit;
  assign tx_ready = state == IDLE;
  assign busy = !tx_ready;
  assign accept = tx_valid && tx_ready;
  assign serial_out = state == SHIFT && shift_reg[WIDTH-1];
  bit_timer #(.WIDTH(WIDTH), .DIV(DIV)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept),
    .run(state == SHIFT),
    .bit_end(bit_end),
    .last_bit(last_bit),
    .sclk(sclk)
  );
  always_comb begin
    state_nxt = state == IDLE  ? (accept ? SHIFT : IDLE) :
                state == SHIFT ? (last_bit ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // rx_data captures the final shift directly so it is valid during DONE alongside rx_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      frame <= accept || (frame && !last_bit);
      if (accept) shift_reg <= tx_data;
      else if (bit_end) shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
      if (last_bit) rx_data <= {shift_reg[WIDTH-2:0], serial_in};
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer (WIDTH=8, DIV=4)
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, serial_out, sclk, frame, rx_valid, busy;
  logic [7:0] rx_data;
  logic loop = 1'b0;
  logic tie = 1'b0;
  logic serial_in;
  int total = 0;
  int bad = 0;
  assign serial_in = loop ? serial_out : tie;
  always #5 clk = ~clk;
  shift_sequencer #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .serial_out(serial_out),
    .serial_in(serial_in),
    .sclk(sclk),
    .frame(frame),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .busy(busy)
  );
  // Called at a negedge in IDLE; returns at the negedge of the first SHIFT cycle (c=0).
  task automatic launch(input logic [7:0] d, input logic hold);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({tx_ready, serial_out, sclk, frame, busy, rx_valid, rx_data} !== {1'b1, 5'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset got=%b exp=%b", {tx_ready, serial_out, sclk, frame, busy, rx_valid, rx_data}, {1'b1, 13'b0});
    end
  endtask
  // Expected vector per cycle: {frame, serial_out, sclk, rx_valid, tx_ready, busy}
  task automatic test_loopback;
    logic [7:0] d = 8'hA5;
    logic [5:0] exp;
    loop = 1'b1;
    @(negedge clk);
    launch(d, 1'b0);
    for (int c = 0; c <= 33; c++) begin
      if (c > 0) @(negedge clk);
      exp = {c < 32, c < 32 ? d[7 - c / 4] : 1'b0, c < 32 && (c % 4) < 2, c == 32, c == 33, c <= 32};
      total++;
      if ({frame, serial_out, sclk, rx_valid, tx_ready, busy} !== exp) begin
        bad++;
        $display("FAIL loopback c=%0d got=%b exp=%b", c, {frame, serial_out, sclk, rx_valid, tx_ready, busy}, exp);
      end
      if (c == 32) begin
        total++;
        if (rx_data !== 8'hA5) begin
          bad++;
          $display("FAIL loopback_rx got=%h exp=a5", rx_data);
        end
      end
    end
  endtask
  task automatic test_tied_one;
    loop = 1'b0;
    tie = 1'b1;
    @(negedge clk);
    launch(8'h00, 1'b0);
    for (int c = 0; c <= 32; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 32) begin
        total++;
        if (serial_out !== 1'b0) begin
          bad++;
          $display("FAIL tied_out c=%0d got=%b exp=0", c, serial_out);
        end
      end
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin
      bad++;
      $display("FAIL tied_rx got=%b/%h exp=1/ff", rx_valid, rx_data);
    end
    tie = 1'b0;
  endtask
  // Second frame (C3) starts at c=34: DONE at 32, one IDLE cycle at 33, accept edge closes 33.
  task automatic test_back_to_back;
    logic [7:0] d;
    int o;
    logic [4:0] exp;
    loop = 1'b1;
    @(negedge clk);
    launch(8'h3C, 1'b1);
    for (int c = 0; c <= 67; c++) begin
      if (c > 0) @(negedge clk);
      d = c < 34 ? 8'h3C : 8'hC3;
      o = c < 34 ? c : c - 34;
      exp = {o < 32, o < 32 ? d[7 - o / 4] : 1'b0, o == 32, c == 33 || c == 67, o <= 32 && c != 33};
      total++;
      if ({frame, serial_out, rx_valid, tx_ready, busy} !== exp) begin
        bad++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, {frame, serial_out, rx_valid, tx_ready, busy}, exp);
      end
      if (c == 32 || c == 66) begin
        total++;
        if (rx_data !== d) begin
          bad++;
          $display("FAIL b2b_rx c=%0d got=%h exp=%h", c, rx_data, d);
        end
      end
      if (c == 5) tx_data = 8'hFF;
      if (c == 32) tx_data = 8'hC3;
      if (c == 34) begin
        tx_valid = 1'b0;
        tx_data = 8'h00;
      end
    end
  endtask
  task automatic test_mid_reset;
    loop = 1'b1;
    @(negedge clk);
    launch(8'h5A, 1'b0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_ready, serial_out, sclk, frame, busy, rx_valid, rx_data} !== {1'b1, 5'b0, 8'h00}) begin
      bad++;
      $display("FAIL midreset got=%b exp=%b", {tx_ready, serial_out, sclk, frame, busy, rx_valid, rx_data}, {1'b1, 13'b0});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (rx_valid !== 1'b0 || frame !== 1'b0) begin
        bad++;
        $display("FAIL midreset_hold c=%0d got=%b%b exp=00", c, rx_valid, frame);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(8'h81, 1'b0);
    repeat (32) @(negedge clk);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
      bad++;
      $display("FAIL midreset_rx got=%b/%h exp=1/81", rx_valid, rx_data);
    end
  endtask
  task automatic test_sclk;
    int highs = 0;
    int rises = 0;
    logic prev = 1'b0;
    loop = 1'b0;
    @(negedge clk);
    total++;
    if (sclk !== 1'b0) begin
      bad++;
      $display("FAIL sclk_idle got=%b exp=0", sclk);
    end
    launch(8'h96, 1'b0);
    for (int c = 0; c <= 33; c++) begin
      if (c > 0) @(negedge clk);
      if (sclk === 1'b1) highs++;
      if (sclk === 1'b1 && !prev) rises++;
      prev = sclk;
      if (c >= 32) begin
        total++;
        if (sclk !== 1'b0) begin
          bad++;
          $display("FAIL sclk_done_idle c=%0d got=%b exp=0", c, sclk);
        end
      end
    end
    total++;
    if (highs != 16 || rises != 8) begin
      bad++;
      $display("FAIL sclk_count got=%0d/%0d exp=16/8", highs, rises);
    end
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_tied_one();
    test_back_to_back();
    test_mid_reset();
    test_sclk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
